// File: rtl/wb_ex_commit_pkg.sv
// Shared definitions for the WB exception/ERET commit controller
// and the WB-to-CP0 register bus it produces.
package wb_ex_commit_pkg;

    localparam int WB_TO_CP0_REGISTER_BUS_WD = 110;

    localparam logic [4:0] EX_INT  = 5'h00;
    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;
    localparam logic [4:0] EX_SYS  = 5'h08;
    localparam logic [4:0] EX_BP   = 5'h09;
    localparam logic [4:0] EX_RI   = 5'h0a;
    localparam logic [4:0] EX_OV   = 5'h0c;

    localparam logic [4:0] CR_BADVADDR = 5'd8;
    localparam logic [4:0] CR_COUNT    = 5'd9;
    localparam logic [4:0] CR_COMPARE  = 5'd11;
    localparam logic [4:0] CR_STATUS   = 5'd12;
    localparam logic [4:0] CR_CAUSE    = 5'd13;
    localparam logic [4:0] CR_EPC      = 5'd14;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic        bd;
        logic [31:0] pc;
        logic        mtc0_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        eret_flush;
    } wb_cp0_bus_t;

    // Only address-error exceptions carry a meaningful BadVAddr.
    function automatic logic has_badvaddr(input logic [4:0] code);
        return (code == EX_ADEL) || (code == EX_ADES);
    endfunction

endpackage

// File: rtl/wb_ex_commit.sv
// WB-stage commit controller: resolves int/ex/ERET/MTC0 at commit,
// drives the CP0 bus and holds a flush + redirect toward fetch.
module wb_ex_commit
    import wb_ex_commit_pkg::*;
#(
    parameter logic [31:0] EX_VECTOR = 32'hBFC0_0380,
    parameter int          FLUSH_MIN = 2
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 ws_valid,
    input  logic [31:0]                          ws_pc,
    input  logic                                 ws_bd,
    input  logic                                 ws_ex,
    input  logic [4:0]                           ws_excode,
    input  logic [31:0]                          ws_badvaddr,
    input  logic                                 ws_eret,
    input  logic                                 ws_mtc0,
    input  logic [4:0]                           ws_c0_addr,
    input  logic [31:0]                          ws_c0_wdata,
    output logic                                 ws_allowin,
    input  logic                                 cp0_has_int,
    input  logic [31:0]                          cp0_epc,
    output logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
    output logic                                 flush_o,
    output logic [31:0]                          flush_pc_o,
    input  logic                                 redirect_ready_i
);

    localparam logic [3:0] L_MIN  = 4'(FLUSH_MIN);
    localparam logic [3:0] L_LAST = 4'(FLUSH_MIN - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_flush;
    logic [31:0] r_flush_pc;

    logic        w_commit;
    logic        w_int;
    logic        w_ex;
    logic        w_exc;
    logic        w_eret;
    logic        w_mtc0;
    wb_cp0_bus_t w_bus;

    // Reset gating keeps the bus quiet while resetn is low.
    assign w_commit = ws_valid & (r_state == ST_IDLE) & resetn;
    assign w_int    = w_commit & cp0_has_int;
    assign w_ex     = w_commit & ~cp0_has_int & ws_ex;
    assign w_exc    = w_int | w_ex;
    assign w_eret   = w_commit & ~cp0_has_int & ~ws_ex & ws_eret;
    assign w_mtc0   = w_commit & ~cp0_has_int & ~ws_ex & ~ws_eret
                    & ws_mtc0;

    assign ws_allowin             = (r_state == ST_IDLE);
    assign wb_to_cp0_register_bus = w_bus;
    assign flush_o                = r_flush;
    assign flush_pc_o             = r_flush_pc;

    // Priority-resolved event fields of the CP0 bus for this commit.
    always_comb begin
        w_bus = '0;
        if (w_exc) begin
            w_bus.ex     = 1'b1;
            w_bus.excode = w_int ? EX_INT : ws_excode;
            w_bus.bd     = ws_bd;
            w_bus.pc     = ws_pc;
            if (w_ex && has_badvaddr(ws_excode)) begin
                w_bus.badvaddr = ws_badvaddr;
            end
        end
        w_bus.eret_flush = w_eret;
        if (w_mtc0) begin
            w_bus.mtc0_we = 1'b1;
            w_bus.waddr   = ws_c0_addr;
            w_bus.wdata   = ws_c0_wdata;
        end
    end

    // Flush FSM: hold flush for at least FLUSH_MIN cycles and until
    // fetch accepts the redirect on or after the last hold cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_flush    <= 1'b0;
            r_flush_pc <= 32'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_exc || w_eret) begin
                        r_state    <= ST_FLUSH;
                        r_cnt      <= 4'd0;
                        r_flush    <= 1'b1;
                        r_flush_pc <= w_exc ? EX_VECTOR : cp0_epc;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt < L_MIN) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                    if ((r_cnt >= L_LAST) && redirect_ready_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                        r_flush <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
